// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and muldiv_unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU unit feeding HI/LO.
// Define MULDIV_EARLY_OUT_EN to short-circuit zero-operand operations.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             dbz;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mag_b;
    logic [CW-1:0]    count;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    assign a_neg = !bus.op[0] && bus.a[WIDTH-1];
    assign b_neg = !bus.op[0] && bus.b[WIDTH-1];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

`ifdef MULDIV_EARLY_OUT_EN
    logic trivial;
    logic skip;
    assign trivial = (bus.b == '0) || (!bus.op[1] && bus.a == '0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            skip <= 1'b0;
        else if (state == IDLE)
            skip <= trivial;
    end
`else
    logic trivial;
    logic skip;
    assign trivial = 1'b0;
    assign skip    = 1'b0;
`endif

    // acc_lo doubles as multiplier shift register and quotient register
    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    assign add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    assign shifted = {acc_hi, acc_lo[WIDTH-1]};
    assign diff    = shifted - {1'b0, mag_b};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_fix  = dbz ? '1 : (neg_q ? -acc_lo : acc_lo);
    assign rem_fix  = neg_r ? -acc_hi : acc_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            mag_b  <= '0;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                        is_div <= bus.op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dbz    <= bus.op[1] && (bus.b == '0);
                        mag_b  <= b_mag;
                        if (trivial) begin
                            // b=0 divide leaves |a| as remainder
                            count  <= '0;
                            acc_hi <= bus.op[1] ? a_mag : '0;
                            acc_lo <= '0;
                        end else begin
                            count  <= CW'(WIDTH - 1);
                            acc_hi <= '0;
                            acc_lo <= a_mag;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        if (!skip && is_div) begin
                            acc_hi <= diff[WIDTH] ? shifted[WIDTH-1:0]
                                                  : diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], !diff[WIDTH]};
                        end else if (!skip) begin
                            acc_hi <= add_sum[WIDTH:1];
                            acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                        end
                        count <= count - CW'(1);
                        if (count == '0)
                            state <= FIX;
                    end
                end
                FIX: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    if (!bus.flush) begin
                        hi_r   <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                        lo_r   <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
                        done_r <= 1'b1;
                        dbz_r  <= dbz;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
endmodule
